serv_fetch_align: RTL and testbench

Parametrised fetch-side instruction aligner and RV32C expander. It sits between the core's instruction bus and the memory-side instruction bus. It accepts halfword-aligned PCs and fetches one or two aligned 32-bit words as needed. It returns a single expanded 32-bit RV32I instruction plus compressed and illegal flags. A one-word buffer serves sequential halfword fetches without a repeat memory access.

---
 rtl/serv_fetch_align.sv | 278 +++++++++++++++++++++++++++
 tb/tb_serv_fetch_align.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serv_fetch_align.sv
// Fetch-side instruction aligner: halfword-aligned PCs, one-word reuse buffer,
// straddling 32-bit instructions over two words, and RV32C to RV32I expansion.
module serv_fetch_align #(
  parameter bit WITH_C        = 1'b1,
  parameter bit ILLEGAL_CHECK = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic [31:0] i_cpu_adr,
  input  logic        i_cpu_cyc,
  output logic [31:0] o_cpu_rdt,
  output logic        o_cpu_ack,
  output logic        o_cpu_iscomp,
  output logic        o_cpu_illegal,
  output logic [31:0] o_mem_adr,
  output logic        o_mem_cyc,
  input  logic [31:0] i_mem_rdt,
  input  logic        i_mem_ack
);

  localparam int unsigned WAW = 30;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_OP  = 7'b0110011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  typedef enum logic [1:0] {IDLE, FETCH_A, FETCH_B, RESP} state_e;

  state_e           state_q, state_d;
  logic [31:0]      buf_q, buf_d;
  logic [WAW-1:0]   buf_adr_q, buf_adr_d;
  logic             buf_v_q, buf_v_d;
  logic [15:0]      lo_q, lo_d, hi_q, hi_d;
  logic [30:0]      req_adr_q, req_adr_d;
  logic [31:0]      rdt_q, rdt_d;
  logic             ack_q, ack_d;
  logic             iscomp_q, iscomp_d;
  logic             illegal_q, illegal_d;
  logic [31:0]      mem_adr_q, mem_adr_d;
  logic             mem_cyc_q, mem_cyc_d;

  logic [WAW-1:0]   cur_a, nxt_a;
  logic             cur_h, hit;
  logic [31:0]      exp_ins;
  logic             exp_ill;
  logic             unused_adr0;

  assign unused_adr0 = i_cpu_adr[0];

  // Returns {illegal, expanded instruction} for a 16-bit encoding.
  function automatic logic [32:0] expand(input logic [15:0] c);
    logic [31:0] ins;
    logic        ill;
    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [20:0] joff;
    logic [12:0] boff;
    ins  = 32'h0;
    ill  = 1'b0;
    rd   = c[11:7];
    rs2  = c[6:2];
    rdp  = {2'b01, c[4:2]};
    rs1p = {2'b01, c[9:7]};
    joff = {{10{c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
    boff = {{5{c[12]}}, c[6:5], c[2], c[11:10], c[4:3], 1'b0};
    case (c[1:0])
      2'b00: begin
        case (c[15:13])
          3'b000: ins = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp, OP_IMM};
          3'b010: ins = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, OP_LD};
          3'b110: ins = {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b00, OP_ST};
          default: ill = 1'b1;
        endcase
      end
      2'b01: begin
        case (c[15:13])
          3'b000: ins = {{7{c[12]}}, c[6:2], rd, 3'b000, rd, OP_IMM};
          3'b001: ins = {joff[20], joff[10:1], joff[11], joff[19:12], 5'd1, OP_JAL};
          3'b010: ins = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, rd, OP_IMM};
          3'b011: begin
            ill = ({c[12], c[6:2]} == 6'd0);
            if (rd == 5'd2)
              ins = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2, OP_IMM};
            else
              ins = {{15{c[12]}}, c[6:2], rd, OP_LUI};
          end
          3'b100: begin
            case (c[11:10])
              2'b00: ins = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, OP_IMM};
              2'b01: ins = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, OP_IMM};
              2'b10: ins = {{7{c[12]}}, c[6:2], rs1p, 3'b111, rs1p, OP_IMM};
              default: begin
                ill = c[12];
                case (c[6:5])
                  2'b00:   ins = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OP_OP};
                  2'b01:   ins = {7'b0000000, rdp, rs1p, 3'b100, rs1p, OP_OP};
                  2'b10:   ins = {7'b0000000, rdp, rs1p, 3'b110, rs1p, OP_OP};
                  default: ins = {7'b0000000, rdp, rs1p, 3'b111, rs1p, OP_OP};
                endcase
              end
            endcase
          end
          3'b101:  ins = {joff[20], joff[10:1], joff[11], joff[19:12], 5'd0, OP_JAL};
          3'b110:  ins = {boff[12], boff[10:5], 5'd0, rs1p, 3'b000, boff[4:1], boff[11], OP_BR};
          default: ins = {boff[12], boff[10:5], 5'd0, rs1p, 3'b001, boff[4:1], boff[11], OP_BR};
        endcase
      end
      2'b10: begin
        case (c[15:13])
          3'b000: ins = {7'b0, c[6:2], rd, 3'b001, rd, OP_IMM};
          3'b010: begin
            ins = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, OP_LD};
            ill = (rd == 5'd0);
          end
          3'b100: begin
            if (!c[12]) begin
              if (rs2 == 5'd0) begin
                ins = {12'b0, rd, 3'b000, 5'd0, OP_JR};
                ill = (rd == 5'd0);
              end else begin
                ins = {7'b0, rs2, 5'd0, 3'b000, rd, OP_OP};
              end
            end else if (rs2 == 5'd0) begin
              ins = (rd == 5'd0) ? 32'h0010_0073 : {12'b0, rd, 3'b000, 5'd1, OP_JR};
            end else begin
              ins = {7'b0, rs2, rd, 3'b000, rd, OP_OP};
            end
          end
          3'b110:  ins = {4'b0, c[8:7], c[12], c[6:2], 5'd2, 3'b010, c[11:9], 2'b00, OP_ST};
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b0;
    endcase
    if (c == 16'h0000) ill = 1'b1;
    return {ill, ins};
  endfunction

  // The PC is taken live while idle and from the latched request afterwards.
  always_comb begin
    cur_a = (state_q == IDLE) ? i_cpu_adr[31:2] : req_adr_q[30:1];
    cur_h = (state_q == IDLE) ? i_cpu_adr[1]    : req_adr_q[0];
    nxt_a = cur_a + WAW'(1);
    hit   = buf_v_q && !i_flush && (buf_adr_q == cur_a);
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    buf_adr_d = buf_adr_q;
    buf_v_d   = buf_v_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    req_adr_d = req_adr_q;
    rdt_d     = rdt_q;
    ack_d     = 1'b0;
    iscomp_d  = iscomp_q;
    illegal_d = illegal_q;
    mem_adr_d = mem_adr_q;
    mem_cyc_d = 1'b0;
    exp_ins   = 32'h0;
    exp_ill   = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_cpu_cyc) begin
          req_adr_d = i_cpu_adr[31:1];
          if (WITH_C && hit) begin
            lo_d = cur_h ? buf_q[31:16] : buf_q[15:0];
            hi_d = buf_q[31:16];
            if (cur_h && (buf_q[17:16] == 2'b11)) begin
              state_d   = FETCH_B;
              mem_adr_d = {nxt_a, 2'b00};
            end else begin
              state_d = RESP;
            end
          end else begin
            state_d   = FETCH_A;
            mem_adr_d = {cur_a, 2'b00};
          end
        end
      end
      FETCH_A: begin
        if (i_mem_ack) begin
          state_d = RESP;
          if (WITH_C) begin
            buf_d     = i_mem_rdt;
            buf_adr_d = cur_a;
            buf_v_d   = 1'b1;
            lo_d      = cur_h ? i_mem_rdt[31:16] : i_mem_rdt[15:0];
            hi_d      = i_mem_rdt[31:16];
            if (cur_h && (i_mem_rdt[17:16] == 2'b11)) begin
              state_d   = FETCH_B;
              mem_adr_d = {nxt_a, 2'b00};
            end
          end
        end
      end
      FETCH_B: begin
        if (i_mem_ack) begin
          hi_d      = i_mem_rdt[15:0];
          buf_d     = i_mem_rdt;
          buf_adr_d = nxt_a;
          buf_v_d   = 1'b1;
          state_d   = RESP;
        end
      end
      default: state_d = IDLE;
    endcase

    if (i_flush) buf_v_d = 1'b0;
    mem_cyc_d = (state_d == FETCH_A) || (state_d == FETCH_B);

    // Response word is formed on the edge that enters RESP.
    if (state_d == RESP) begin
      ack_d = 1'b1;
      {exp_ill, exp_ins} = expand(lo_d);
      if (!WITH_C) begin
        rdt_d     = i_mem_rdt;
        iscomp_d  = 1'b0;
        illegal_d = 1'b0;
      end else if (lo_d[1:0] == 2'b11) begin
        rdt_d     = {hi_d, lo_d};
        iscomp_d  = 1'b0;
        illegal_d = 1'b0;
      end else begin
        iscomp_d  = 1'b1;
        illegal_d = ILLEGAL_CHECK && exp_ill;
        rdt_d     = (ILLEGAL_CHECK && exp_ill) ? {16'h0000, lo_d} : exp_ins;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      buf_q     <= 32'h0;
      buf_adr_q <= '0;
      buf_v_q   <= 1'b0;
      lo_q      <= 16'h0;
      hi_q      <= 16'h0;
      req_adr_q <= 31'h0;
      rdt_q     <= 32'h0;
      ack_q     <= 1'b0;
      iscomp_q  <= 1'b0;
      illegal_q <= 1'b0;
      mem_adr_q <= 32'h0;
      mem_cyc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      buf_adr_q <= buf_adr_d;
      buf_v_q   <= buf_v_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      req_adr_q <= req_adr_d;
      rdt_q     <= rdt_d;
      ack_q     <= ack_d;
      iscomp_q  <= iscomp_d;
      illegal_q <= illegal_d;
      mem_adr_q <= mem_adr_d;
      mem_cyc_q <= mem_cyc_d;
    end
  end

  assign o_cpu_rdt     = rdt_q;
  assign o_cpu_ack     = ack_q;
  assign o_cpu_iscomp  = iscomp_q;
  assign o_cpu_illegal = illegal_q;
  assign o_mem_adr     = mem_adr_q;
  assign o_mem_cyc     = mem_cyc_q;

endmodule

// File: tb/tb_serv_fetch_align.sv
// Directed bench for serv_fetch_align: one compressed-capable instance and one
// pass-through instance share a bus model selected by sel_nc.
module tb_serv_fetch_align;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] cpu_adr = 32'h0;
  logic        cpu_cyc = 1'b0;
  logic [31:0] mem_rdt = 32'h0;
  logic        mem_ack = 1'b0;
  logic        sel_nc = 1'b0;

  logic [31:0] rdt_c, rdt_n, madr_c, madr_n;
  logic        ack_c, ack_n, isc_c, isc_n, ill_c, ill_n, mcyc_c, mcyc_n;

  logic [31:0] rdt_o, madr_o;
  logic        ack_o, isc_o, ill_o, mcyc_o;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] r_rdt, r_adr0, r_adr1;
  logic        r_isc, r_ill, r_cyc_resp, r_ack_after;
  int          r_ack_cyc, r_nmem;

  always #5 clk = ~clk;

  assign rdt_o  = sel_nc ? rdt_n  : rdt_c;
  assign madr_o = sel_nc ? madr_n : madr_c;
  assign ack_o  = sel_nc ? ack_n  : ack_c;
  assign isc_o  = sel_nc ? isc_n  : isc_c;
  assign ill_o  = sel_nc ? ill_n  : ill_c;
  assign mcyc_o = sel_nc ? mcyc_n : mcyc_c;

  serv_fetch_align #(.WITH_C(1'b1), .ILLEGAL_CHECK(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_cpu_adr(cpu_adr), .i_cpu_cyc(cpu_cyc && !sel_nc),
    .o_cpu_rdt(rdt_c), .o_cpu_ack(ack_c), .o_cpu_iscomp(isc_c), .o_cpu_illegal(ill_c),
    .o_mem_adr(madr_c), .o_mem_cyc(mcyc_c),
    .i_mem_rdt(mem_rdt), .i_mem_ack(mem_ack && !sel_nc)
  );

  serv_fetch_align #(.WITH_C(1'b0), .ILLEGAL_CHECK(1'b1)) dut_nc (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_cpu_adr(cpu_adr), .i_cpu_cyc(cpu_cyc && sel_nc),
    .o_cpu_rdt(rdt_n), .o_cpu_ack(ack_n), .o_cpu_iscomp(isc_n), .o_cpu_illegal(ill_n),
    .o_mem_adr(madr_n), .o_mem_cyc(mcyc_n),
    .i_mem_rdt(mem_rdt), .i_mem_ack(mem_ack && sel_nc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h4501_0405;
      32'h0000_0100: return 32'h0093_1234;
      32'h0000_0104: return 32'h4501_0010;
      32'h0000_0200: return 32'h4002_0000;
      32'h0000_0400: return 32'h852e_8082;
      32'h0000_0500: return 32'h6105_c401;
      32'hffff_fffc: return 32'h0093_0000;
      default:       return 32'h0000_0001;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One CPU request; memory answers each request after lat extra cycles.
  task automatic fetch(input logic [31:0] pc, input int lat, input bit flush_acc);
    int  wcnt;
    bit  done;
    wcnt = 0; done = 1'b0;
    r_nmem = 0; r_ack_cyc = -1; r_adr0 = 32'h0; r_adr1 = 32'h0;
    r_rdt = 32'h0; r_isc = 1'b0; r_ill = 1'b0; r_cyc_resp = 1'b1;
    cpu_adr = pc; cpu_cyc = 1'b1; flush = flush_acc;
    for (int n = 1; n <= 40 && !done; n++) begin
      @(posedge clk); #1;
      flush = 1'b0; mem_ack = 1'b0;
      if (ack_o) begin
        r_rdt = rdt_o; r_isc = isc_o; r_ill = ill_o; r_cyc_resp = mcyc_o;
        r_ack_cyc = n; cpu_cyc = 1'b0; done = 1'b1;
      end else if (mcyc_o) begin
        if (wcnt == lat) begin
          mem_ack = 1'b1;
          mem_rdt = mem_word(madr_o);
          if (r_nmem == 0) r_adr0 = madr_o; else r_adr1 = madr_o;
          r_nmem++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
    cpu_cyc = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    r_ack_after = ack_o;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack",  32'(ack_o), 32'h0);
    chk("rst_mcyc", 32'(mcyc_o), 32'h0);
    chk("rst_rdt",  rdt_o, 32'h0);
    chk("rst_madr", madr_o, 32'h0);
    chk("rst_isc",  32'(isc_o), 32'h0);
    chk("rst_ill",  32'(ill_o), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    fetch(32'h0, 1, 1'b0);
    chk("pc0_rdt", r_rdt, 32'h0014_0413);
    chk("pc0_isc", 32'(r_isc), 32'h1);
    chk("pc0_ill", 32'(r_ill), 32'h0);
    chk("pc0_nmem", 32'(r_nmem), 32'd1);
    chk("pc0_adr", r_adr0, 32'h0);
    chk("pc0_lat", 32'(r_ack_cyc), 32'd3);
    chk("pc0_cyc_resp", 32'(r_cyc_resp), 32'h0);
    chk("pc0_ack_once", 32'(r_ack_after), 32'h0);

    fetch(32'h2, 0, 1'b0);
    chk("pc2_rdt", r_rdt, 32'h0000_0513);
    chk("pc2_nmem", 32'(r_nmem), 32'd0);
    chk("pc2_lat", 32'(r_ack_cyc), 32'd1);
    chk("pc2_isc", 32'(r_isc), 32'h1);

    fetch(32'h102, 0, 1'b0);
    chk("strad_rdt", r_rdt, 32'h0010_0093);
    chk("strad_isc", 32'(r_isc), 32'h0);
    chk("strad_nmem", 32'(r_nmem), 32'd2);
    chk("strad_adr0", r_adr0, 32'h100);
    chk("strad_adr1", r_adr1, 32'h104);
    chk("strad_lat", 32'(r_ack_cyc), 32'd3);

    fetch(32'h106, 0, 1'b0);
    chk("pc106_rdt", r_rdt, 32'h0000_0513);
    chk("pc106_nmem", 32'(r_nmem), 32'd0);
    chk("pc106_lat", 32'(r_ack_cyc), 32'd1);

    fetch(32'h200, 0, 1'b0);
    chk("zero_ill", 32'(r_ill), 32'h1);
    chk("zero_rdt", r_rdt, 32'h0);
    fetch(32'h202, 0, 1'b0);
    chk("lwsp0_ill", 32'(r_ill), 32'h1);
    chk("lwsp0_rdt", r_rdt, 32'h0000_4002);

    fetch(32'h400, 0, 1'b0);
    chk("jr_rdt", r_rdt, 32'h0000_8067);
    chk("jr_ill", 32'(r_ill), 32'h0);
    fetch(32'h402, 0, 1'b0);
    chk("mv_rdt", r_rdt, 32'h00b0_0533);
    fetch(32'h500, 0, 1'b0);
    chk("beqz_rdt", r_rdt, 32'h0004_0463);
    fetch(32'h502, 0, 1'b0);
    chk("a16sp_rdt", r_rdt, 32'h0201_0113);
    chk("a16sp_nmem", 32'(r_nmem), 32'd0);

    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    fetch(32'h502, 0, 1'b0);
    chk("flush_nmem", 32'(r_nmem), 32'd1);
    chk("flush_rdt", r_rdt, 32'h0201_0113);
    fetch(32'h500, 0, 1'b1);
    chk("flush_acc_nmem", 32'(r_nmem), 32'd1);
    chk("flush_acc_rdt", r_rdt, 32'h0004_0463);

    fetch(32'h100, 0, 1'b0);
    fetch(32'h102, 0, 1'b0);
    chk("hstrad_rdt", r_rdt, 32'h0010_0093);
    chk("hstrad_nmem", 32'(r_nmem), 32'd1);
    chk("hstrad_adr", r_adr0, 32'h104);
    chk("hstrad_lat", 32'(r_ack_cyc), 32'd2);

    fetch(32'hffff_fffe, 0, 1'b0);
    chk("wrap_adr1", r_adr1, 32'h0);
    chk("wrap_rdt", r_rdt, 32'h0405_0093);

    cpu_adr = 32'h300; cpu_cyc = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_cyc", 32'(mcyc_o), 32'h1);
    rst = 1'b1; cpu_cyc = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid_cyc_off", 32'(mcyc_o), 32'h0);
    mem_ack = 1'b1; mem_rdt = 32'h0000_0001;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rstmid_no_ack", 32'(ack_o), 32'h0);
      chk("rstmid_no_cyc", 32'(mcyc_o), 32'h0);
      @(posedge clk); #1;
    end

    sel_nc = 1'b1;
    fetch(32'h2, 0, 1'b0);
    chk("nc_rdt", r_rdt, 32'h4501_0405);
    chk("nc_adr", r_adr0, 32'h0);
    chk("nc_nmem", 32'(r_nmem), 32'd1);
    chk("nc_isc", 32'(r_isc), 32'h0);
    chk("nc_lat", 32'(r_ack_cyc), 32'd2);
    fetch(32'h2, 0, 1'b0);
    chk("nc_nobuf_nmem", 32'(r_nmem), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
